// File: rtl/uc_seq_pkg.sv
// Shared definitions for the microcode sequencer: op encoding, default widths,
// and the select-width helper used for the condition index port.
package uc_seq_pkg;

    localparam int DEF_ADDR_W      = 12;
    localparam int DEF_STACK_DEPTH = 4;
    localparam int DEF_COND_W      = 8;
    localparam int DEF_CTR_W       = 8;

    typedef enum logic [2:0] {
        OP_NEXT   = 3'd0,
        OP_JUMP   = 3'd1,
        OP_CALL   = 3'd2,
        OP_RETURN = 3'd3,
        OP_MAP    = 3'd4,
        OP_LDCTR  = 3'd5,
        OP_LOOP   = 3'd6,
        OP_HOLD   = 3'd7
    } uc_op_e;

    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uc_stack.sv
// LIFO return-address stack; push into a full stack and pop from an empty one are ignored.
// One-cycle update, dout shows the current top entry combinationally.
module uc_stack
    import uc_seq_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             push,
    input  logic                             pop,
    input  logic [ADDR_W-1:0]                din,
    output logic [ADDR_W-1:0]                dout,
    output logic                             full,
    output logic                             empty,
    output logic [$clog2(STACK_DEPTH+1)-1:0] sp
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam logic [SP_W-1:0] FULL_LVL = SP_W'(STACK_DEPTH);

    logic [ADDR_W-1:0] mem_q [2**IDX_W];
    logic [SP_W-1:0]   sp_q;
    logic [SP_W-1:0]   sp_d;
    logic [IDX_W-1:0]  rd_idx;

    assign full   = (sp_q == FULL_LVL);
    assign empty  = (sp_q == '0);
    assign sp     = sp_q;
    // Low bits of sp-1 address the top entry for every occupancy 1..STACK_DEPTH.
    assign rd_idx = sp_q[IDX_W-1:0] - IDX_W'(1);
    assign dout   = mem_q[rd_idx];

    always_comb begin
        sp_d = sp_q;
        if (push && !full) begin
            sp_d = sp_q + SP_W'(1);
        end else if (pop && !empty) begin
            sp_d = sp_q - SP_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push && !full) begin
            mem_q[sp_q[IDX_W-1:0]] <= din;
        end
    end

endmodule

// File: rtl/uc_sequencer.sv
// Microcode address sequencer: registered upc with jump/call/return/map/loop ops.
// Optional sticky stack error flag when UC_SEQ_STACK_CHECK_EN is defined; stall freezes all state.
module uc_sequencer
    import uc_seq_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH,
    parameter int COND_W      = DEF_COND_W,
    parameter int CTR_W       = DEF_CTR_W
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             stall,
    input  logic [2:0]                       op,
    input  logic [ADDR_W-1:0]                d_in,
    input  logic [ADDR_W-1:0]                map_in,
    input  logic [COND_W-1:0]                cond,
    input  logic [sel_w(COND_W)-1:0]         cond_sel,
    input  logic                             cond_inv,
    output logic [ADDR_W-1:0]                uc_address,
    output logic                             ctr_zero,
    output logic [$clog2(STACK_DEPTH+1)-1:0] sp,
    output logic                             stack_err
);

    localparam int SEL_W = sel_w(COND_W);

    logic [ADDR_W-1:0]    upc_q, upc_d, upc_inc;
    logic [CTR_W-1:0]     ctr_q, ctr_d;
    logic [2**SEL_W-1:0]  cond_ext;
    logic                 taken;
    logic                 stk_push, stk_pop, stk_full, stk_empty;
    logic [ADDR_W-1:0]    stk_top;

    // Zero-extend so out-of-range selects read as 0 without a compare.
    always_comb begin
        cond_ext             = '0;
        cond_ext[COND_W-1:0] = cond;
    end

    assign taken   = cond_ext[cond_sel] ^ cond_inv;
    assign upc_inc = upc_q + ADDR_W'(1);

    assign stk_push = !stall && taken && (op == OP_CALL);
    assign stk_pop  = !stall && taken && (op == OP_RETURN);

    uc_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clock (clock),
        .reset (reset),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (upc_inc),
        .dout  (stk_top),
        .full  (stk_full),
        .empty (stk_empty),
        .sp    (sp)
    );

    always_comb begin
        upc_d = upc_inc;
        ctr_d = ctr_q;
        case (op)
            OP_NEXT:   upc_d = upc_inc;
            OP_JUMP:   upc_d = taken ? d_in : upc_inc;
            OP_CALL:   upc_d = taken ? d_in : upc_inc;
            OP_RETURN: upc_d = (taken && !stk_empty) ? stk_top : upc_inc;
            OP_MAP:    upc_d = map_in;
            OP_LDCTR:  ctr_d = d_in[CTR_W-1:0];
            OP_LOOP: begin
                if (ctr_q != '0) begin
                    ctr_d = ctr_q - CTR_W'(1);
                    upc_d = d_in;
                end
            end
            OP_HOLD:   upc_d = upc_q;
            default:   upc_d = upc_inc;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            upc_q <= '0;
            ctr_q <= '0;
        end else if (!stall) begin
            upc_q <= upc_d;
            ctr_q <= ctr_d;
        end
    end

    assign uc_address = upc_q;
    assign ctr_zero   = (ctr_q == '0);

`ifdef UC_SEQ_STACK_CHECK_EN
    logic stack_err_q, stack_err_d;
    logic ovf_evt, unf_evt;

    assign ovf_evt     = taken && (op == OP_CALL)   && stk_full;
    assign unf_evt     = taken && (op == OP_RETURN) && stk_empty;
    assign stack_err_d = stack_err_q | ovf_evt | unf_evt;

    always_ff @(posedge clock) begin
        if (!reset) begin
            stack_err_q <= 1'b0;
        end else if (!stall) begin
            stack_err_q <= stack_err_d;
        end
    end

    assign stack_err = stack_err_q;
`else
    assign stack_err = 1'b0;
`endif

endmodule

// File: tb/tb_uc_sequencer.sv
// Vector-table bench for uc_sequencer with an expectation queue, plus a hand-run loop sequence.
// COND_W=6 so that cond_sel values 6 and 7 exercise the out-of-range path.
module tb_uc_sequencer;

    localparam logic [2:0] NXT = 3'd0, JMP = 3'd1, CAL = 3'd2, RET = 3'd3,
                           MAP = 3'd4, LDC = 3'd5, LOP = 3'd6, HLD = 3'd7;
`ifdef UC_SEQ_STACK_CHECK_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic        clock, reset, stall, cond_inv;
    logic [2:0]  op, cond_sel, sp;
    logic [11:0] d_in, map_in, uc_address;
    logic [5:0]  cond;
    logic        ctr_zero, stack_err;

    uc_sequencer #(
        .ADDR_W      (12),
        .STACK_DEPTH (4),
        .COND_W      (6),
        .CTR_W       (8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .stall      (stall),
        .op         (op),
        .d_in       (d_in),
        .map_in     (map_in),
        .cond       (cond),
        .cond_sel   (cond_sel),
        .cond_inv   (cond_inv),
        .uc_address (uc_address),
        .ctr_zero   (ctr_zero),
        .sp         (sp),
        .stack_err  (stack_err)
    );

    typedef struct {
        logic        rst;
        logic        stl;
        logic [2:0]  op;
        logic [11:0] d;
        logic [11:0] m;
        logic [5:0]  c;
        logic [2:0]  cs;
        logic        ci;
        logic [11:0] e_addr;
        logic [2:0]  e_sp;
        logic        e_zero;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic add(input logic rst, input logic stl, input logic [2:0] o,
                       input logic [11:0] d, input logic [11:0] m, input logic [5:0] c,
                       input logic [2:0] cs, input logic ci, input logic [11:0] ea,
                       input logic [2:0] esp, input logic ez, input logic ee);
        vec_t v;
        v.rst = rst; v.stl = stl; v.op = o; v.d = d; v.m = m; v.c = c;
        v.cs = cs; v.ci = ci; v.e_addr = ea; v.e_sp = esp; v.e_zero = ez; v.e_err = ee;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", nm, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        @(negedge clock);
        reset = v.rst; stall = v.stl; op = v.op; d_in = v.d; map_in = v.m;
        cond = v.c; cond_sel = v.cs; cond_inv = v.ci;
        exp_q.push_back(v);
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        check("uc_address", idx, 32'(uc_address), 32'(e.e_addr));
        check("sp",         idx, 32'(sp),         32'(e.e_sp));
        check("ctr_zero",   idx, 32'(ctr_zero),   32'(e.e_zero));
        check("stack_err",  idx, 32'(stack_err),  32'(e.e_err & ERR_ON));
    endtask

    initial begin
        int branches;
        bit done;
        reset = 1'b0; stall = 1'b0; op = NXT; d_in = '0; map_in = '0;
        cond = '0; cond_sel = '0; cond_inv = 1'b0;

        // rst stl op   d       m       c      cs ci  addr    sp z  err
        add(0, 0, NXT, 12'h0,   12'h0,  6'h00, 0, 0, 12'h000, 0, 1, 0);
        for (int i = 1; i <= 5; i++)
            add(1, 0, NXT, 12'h0, 12'h0, 6'h00, 0, 0, 12'(i), 0, 1, 0);
        add(1, 0, JMP, 12'h100, 12'h0,  6'h01, 0, 0, 12'h100, 0, 1, 0);
        add(1, 0, JMP, 12'h100, 12'h0,  6'h01, 0, 1, 12'h101, 0, 1, 0);
        add(1, 0, JMP, 12'h300, 12'h0,  6'h20, 5, 0, 12'h300, 0, 1, 0);
        add(1, 0, JMP, 12'h123, 12'h0,  6'h1F, 5, 0, 12'h301, 0, 1, 0);
        add(1, 0, MAP, 12'h0,   12'h010, 6'h00, 0, 0, 12'h010, 0, 1, 0);
        add(1, 0, CAL, 12'h200, 12'h0,  6'h01, 0, 0, 12'h200, 1, 1, 0);
        add(1, 0, RET, 12'h0,   12'h0,  6'h01, 0, 0, 12'h011, 0, 1, 0);
        add(1, 0, RET, 12'h3AA, 12'h0,  6'h00, 0, 0, 12'h012, 0, 1, 0);
        add(1, 0, CAL, 12'h555, 12'h0,  6'h00, 0, 0, 12'h013, 0, 1, 0);
        add(1, 0, LDC, 12'h003, 12'h0,  6'h00, 0, 0, 12'h014, 0, 0, 0);
        add(1, 0, LOP, 12'h040, 12'h0,  6'h00, 0, 0, 12'h040, 0, 0, 0);
        add(1, 0, LOP, 12'h040, 12'h0,  6'h00, 0, 0, 12'h040, 0, 0, 0);
        add(1, 0, LOP, 12'h040, 12'h0,  6'h00, 0, 0, 12'h040, 0, 1, 0);
        add(1, 0, LOP, 12'h040, 12'h0,  6'h00, 0, 0, 12'h041, 0, 1, 0);
        add(1, 0, HLD, 12'h0,   12'h0,  6'h00, 0, 0, 12'h041, 0, 1, 0);
        for (int i = 0; i < 3; i++)
            add(1, 1, JMP, 12'h700, 12'h0, 6'h01, 0, 0, 12'h041, 0, 1, 0);
        add(1, 0, JMP, 12'h700, 12'h0,  6'h01, 0, 0, 12'h700, 0, 1, 0);
        add(1, 1, LDC, 12'h005, 12'h0,  6'h00, 0, 0, 12'h700, 0, 1, 0);
        add(1, 0, NXT, 12'h0,   12'h0,  6'h00, 0, 0, 12'h701, 0, 1, 0);
        for (int k = 0; k < 4; k++)
            add(1, 0, CAL, 12'h400 + 12'(16 * k), 12'h0, 6'h01, 0, 0,
                12'h400 + 12'(16 * k), 3'(k + 1), 1, 0);
        add(1, 0, CAL, 12'h440, 12'h0,  6'h01, 0, 0, 12'h440, 4, 1, 1);
        add(1, 1, RET, 12'h0,   12'h0,  6'h01, 0, 0, 12'h440, 4, 1, 1);
        add(1, 0, RET, 12'h0,   12'h0,  6'h01, 0, 0, 12'h421, 3, 1, 1);
        add(1, 0, RET, 12'h0,   12'h0,  6'h01, 0, 0, 12'h411, 2, 1, 1);
        add(1, 0, RET, 12'h0,   12'h0,  6'h01, 0, 0, 12'h401, 1, 1, 1);
        add(1, 0, RET, 12'h0,   12'h0,  6'h01, 0, 0, 12'h702, 0, 1, 1);
        add(1, 0, RET, 12'h0,   12'h0,  6'h01, 0, 0, 12'h703, 0, 1, 1);
        add(0, 1, JMP, 12'h7FF, 12'h0,  6'h01, 0, 0, 12'h000, 0, 1, 0);
        add(1, 0, JMP, 12'hFFF, 12'h0,  6'h01, 0, 0, 12'hFFF, 0, 1, 0);
        add(1, 0, NXT, 12'h0,   12'h0,  6'h00, 0, 0, 12'h000, 0, 1, 0);
        add(1, 0, JMP, 12'h222, 12'h0,  6'h3F, 6, 0, 12'h001, 0, 1, 0);
        add(1, 0, JMP, 12'h222, 12'h0,  6'h00, 7, 1, 12'h222, 0, 1, 0);
        add(1, 0, LDC, 12'h002, 12'h0,  6'h00, 0, 0, 12'h223, 0, 0, 0);
        add(1, 0, LOP, 12'h050, 12'h0,  6'h00, 0, 0, 12'h050, 0, 0, 0);
        add(0, 0, LOP, 12'h050, 12'h0,  6'h00, 0, 0, 12'h000, 0, 1, 0);
        add(1, 0, LOP, 12'h050, 12'h0,  6'h00, 0, 0, 12'h001, 0, 1, 0);
        add(1, 0, CAL, 12'h600, 12'h0,  6'h01, 0, 0, 12'h600, 1, 1, 0);
        add(0, 0, CAL, 12'h610, 12'h0,  6'h01, 0, 0, 12'h000, 0, 1, 0);
        add(1, 0, RET, 12'h0,   12'h0,  6'h01, 0, 0, 12'h001, 0, 1, 1);
        add(1, 0, LDC, 12'h100, 12'h0,  6'h00, 0, 0, 12'h002, 0, 1, 1);
        add(1, 0, MAP, 12'h0,   12'hABC, 6'h00, 0, 0, 12'hABC, 0, 1, 1);
        add(1, 0, LDC, 12'h00A, 12'h0,  6'h00, 0, 0, 12'hABD, 0, 0, 1);

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], i);

        // Long loop run: ten branches back to 0x040, then fall-through, bounded.
        branches = 0;
        done = 1'b0;
        for (int cyc = 0; cyc < 20 && !done; cyc++) begin
            @(negedge clock);
            reset = 1'b1; stall = 1'b0; op = LOP; d_in = 12'h040; cond = '0;
            @(posedge clock);
            #1;
            if (uc_address == 12'h040) branches++;
            else done = 1'b1;
        end
        check("loop_branches", 0, 32'(branches), 32'd10);
        check("loop_exit_addr", 0, 32'(uc_address), 32'h041);
        check("loop_ctr_zero", 0, 32'(ctr_zero), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
